// File: rtl/axis_splitter.sv
// AXI-Stream packet splitter: cuts each input packet into NUM_STREAMS
// consecutive segments and routes segment k to output stream k.
module axis_splitter #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_STREAMS    = 2,
    parameter int LEN_BITS       = 8
) (
    input  logic                                   clk,
    input  logic                                   sresetn,
    output logic                                   axis_i_tready,
    input  logic                                   axis_i_tvalid,
    input  logic                                   axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]                axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0]              axis_i_tuser,
    input  logic [((NUM_STREAMS > 1) ? NUM_STREAMS-1 : 1)*LEN_BITS-1:0] seg_len_i,
    input  logic [NUM_STREAMS-1:0]                 axis_o_tready,
    output logic [NUM_STREAMS-1:0]                 axis_o_tvalid,
    output logic [NUM_STREAMS-1:0]                 axis_o_tlast,
    output logic [NUM_STREAMS*AXIS_BYTES*8-1:0]    axis_o_tdata,
    output logic [NUM_STREAMS*AXIS_USER_BITS-1:0]  axis_o_tuser,
    output logic                                   runt_o
);

    localparam int DW = AXIS_BYTES * 8;
    localparam int NL = (NUM_STREAMS > 1) ? NUM_STREAMS - 1 : 1;
    localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    logic [IW-1:0]          idx;
    logic [LEN_BITS-1:0]    beat;
    logic [LEN_BITS-1:0]    cur_len;
    logic [NL*LEN_BITS-1:0] len_q;
    logic                   sop;
    logic                   is_last;
    logic                   seg_end;
    logic                   accept;

    // The first beat of a packet sees the live length; later beats the captured copy.
    always_comb begin
        cur_len = seg_len_i[LEN_BITS-1:0];
        if (!sop) begin
            cur_len = '0;
            for (int k = 0; k < NL; k++) begin
                if (idx == IW'(k)) cur_len = len_q[k*LEN_BITS +: LEN_BITS];
            end
        end
    end

    assign is_last       = (idx == IW'(NUM_STREAMS - 1));
    assign seg_end       = axis_i_tlast || (!is_last && (beat == cur_len));
    assign axis_i_tready = axis_o_tready[idx];
    assign accept        = axis_i_tvalid && axis_i_tready;

    for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_out
        assign axis_o_tvalid[k] = axis_i_tvalid && (idx == IW'(k));
        assign axis_o_tlast[k]  = seg_end && (idx == IW'(k));
        assign axis_o_tdata[k*DW +: DW] = axis_i_tdata;
        assign axis_o_tuser[k*AXIS_USER_BITS +: AXIS_USER_BITS] = axis_i_tuser;
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            idx    <= '0;
            beat   <= '0;
            sop    <= 1'b1;
            len_q  <= '0;
            runt_o <= 1'b0;
        end else begin
            runt_o <= 1'b0;
            if (accept) begin
                if (sop) len_q <= seg_len_i;
                if (axis_i_tlast) begin
                    idx    <= '0;
                    beat   <= '0;
                    sop    <= 1'b1;
                    runt_o <= !is_last;
                end else if (seg_end) begin
                    idx  <= idx + IW'(1);
                    beat <= '0;
                    sop  <= 1'b0;
                end else begin
                    // The last stream is unbounded, so its counter is frozen.
                    if (!is_last) beat <= beat + LEN_BITS'(1);
                    sop <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_splitter.sv
// Self-checking bench for axis_splitter: directed vector table, corner
// sequences and a randomized run against a segment-level reference model.
module tb_axis_splitter;

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic [7:0]  din = '0;
    logic        tlast = 1'b0;
    logic        tuser = 1'b0;
    logic [15:0] seg_len = '0;
    logic        v3 = 1'b0;
    logic        v2 = 1'b0;
    logic [2:0]  ordy3 = '0;
    logic [1:0]  ordy2 = '0;

    logic        tready3, runt3;
    logic [2:0]  tvalid3, tlast3, tuser3;
    logic [23:0] tdata3;
    logic        tready2, runt2;
    logic [1:0]  tvalid2, tlast2, tuser2;
    logic [15:0] tdata2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_splitter #(
        .AXIS_BYTES(1), .AXIS_USER_BITS(1), .NUM_STREAMS(3), .LEN_BITS(8)
    ) dut3 (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tready(tready3), .axis_i_tvalid(v3), .axis_i_tlast(tlast),
        .axis_i_tdata(din), .axis_i_tuser(tuser), .seg_len_i(seg_len),
        .axis_o_tready(ordy3), .axis_o_tvalid(tvalid3), .axis_o_tlast(tlast3),
        .axis_o_tdata(tdata3), .axis_o_tuser(tuser3), .runt_o(runt3)
    );

    axis_splitter #(
        .AXIS_BYTES(1), .AXIS_USER_BITS(1), .NUM_STREAMS(2), .LEN_BITS(8)
    ) dut2 (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tready(tready2), .axis_i_tvalid(v2), .axis_i_tlast(tlast),
        .axis_i_tdata(din), .axis_i_tuser(tuser), .seg_len_i(seg_len[7:0]),
        .axis_o_tready(ordy2), .axis_o_tvalid(tvalid2), .axis_o_tlast(tlast2),
        .axis_o_tdata(tdata2), .axis_o_tuser(tuser2), .runt_o(runt2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        sresetn = 1'b0;
        v3 = 1'b0;
        v2 = 1'b0;
        @(posedge clk);
        #1 sresetn = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic [15:0] len;
        int          s;
        logic        t;
        logic        r;
    } vec_t;

    vec_t vt [22];

    // Randomized-run reference: expected {tlast, data} per stream.
    logic [8:0] expq [3][$];
    logic [8:0] e;
    int  runt_cnt = 0;
    int  exp_runt = 0;
    logic mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!v3) chk("idle_valid", {29'd0, tvalid3}, 32'd0);
            if (tvalid3 != 3'b000) begin
                chk("onehot", $countones(tvalid3), 32'd1);
                chk("tready_sel", {31'd0, tready3}, {31'd0, |(tvalid3 & ordy3)});
            end
            for (int k = 0; k < 3; k++) begin
                if (tvalid3[k] && ordy3[k]) begin
                    chk("q_nonempty", {31'd0, expq[k].size() != 0}, 32'd1);
                    if (expq[k].size() != 0) begin
                        e = expq[k].pop_front();
                        chk($sformatf("beat_s%0d", k),
                            {23'd0, tlast3[k], tdata3[k*8 +: 8]}, {23'd0, e});
                    end
                end
            end
            if (runt3) runt_cnt++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, f0, f1, n0, n1, s, waitn, c0, c1, l0, l1, r2;
        logic acc, lst;
        logic [7:0] by;

        vt[0]  = '{8'h00, 1'b0, 16'h0201, 0, 1'b0, 1'b0};
        vt[1]  = '{8'h01, 1'b0, 16'h0201, 0, 1'b1, 1'b0};
        vt[2]  = '{8'h02, 1'b0, 16'h0201, 1, 1'b0, 1'b0};
        vt[3]  = '{8'h03, 1'b0, 16'h0201, 1, 1'b0, 1'b0};
        vt[4]  = '{8'h04, 1'b0, 16'h0201, 1, 1'b1, 1'b0};
        vt[5]  = '{8'h05, 1'b0, 16'h0201, 2, 1'b0, 1'b0};
        vt[6]  = '{8'h06, 1'b0, 16'h0201, 2, 1'b0, 1'b0};
        vt[7]  = '{8'h07, 1'b1, 16'h0201, 2, 1'b1, 1'b0};
        vt[8]  = '{8'hA0, 1'b0, 16'h0201, 0, 1'b0, 1'b0};
        vt[9]  = '{8'hA1, 1'b0, 16'h0201, 0, 1'b1, 1'b0};
        vt[10] = '{8'hA2, 1'b1, 16'h0201, 1, 1'b1, 1'b1};
        vt[11] = '{8'hC0, 1'b0, 16'h0200, 0, 1'b1, 1'b0};
        vt[12] = '{8'hC1, 1'b0, 16'h0203, 1, 1'b0, 1'b0};
        vt[13] = '{8'hC2, 1'b0, 16'h0203, 1, 1'b0, 1'b0};
        vt[14] = '{8'hC3, 1'b0, 16'h0203, 1, 1'b1, 1'b0};
        vt[15] = '{8'hC4, 1'b0, 16'h0203, 2, 1'b0, 1'b0};
        vt[16] = '{8'hC5, 1'b1, 16'h0203, 2, 1'b1, 1'b0};
        vt[17] = '{8'hD0, 1'b0, 16'h0203, 0, 1'b0, 1'b0};
        vt[18] = '{8'hD1, 1'b0, 16'h0203, 0, 1'b0, 1'b0};
        vt[19] = '{8'hD2, 1'b0, 16'h0203, 0, 1'b0, 1'b0};
        vt[20] = '{8'hD3, 1'b0, 16'h0203, 0, 1'b1, 1'b0};
        vt[21] = '{8'hD4, 1'b1, 16'h0203, 1, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1 sresetn = 1'b1;

        // Reset state: stream 0 selected, no runt.
        v3 = 1'b1; ordy3 = 3'b111; din = 8'h55;
        #3;
        chk("rst_tvalid", {29'd0, tvalid3}, 32'd1);
        chk("rst_tready", {31'd0, tready3}, 32'd1);
        chk("rst_runt", {31'd0, runt3}, 32'd0);
        ordy3 = 3'b110;
        #1;
        chk("rst_tready_sel", {31'd0, tready3}, 32'd0);
        chk("rst_valid_stall", {29'd0, tvalid3}, 32'd1);
        @(posedge clk);
        #1 v3 = 1'b0;

        // Directed vector table, all streams ready.
        for (int i = 0; i < 22; i++) begin
            din = vt[i].d; tlast = vt[i].l; tuser = vt[i].d[0];
            seg_len = vt[i].len; v3 = 1'b1; ordy3 = 3'b111;
            #3;
            chk($sformatf("v%0d_tvalid", i), {29'd0, tvalid3},
                32'd1 << vt[i].s);
            chk($sformatf("v%0d_tlast", i), {31'd0, tlast3[vt[i].s]},
                {31'd0, vt[i].t});
            chk($sformatf("v%0d_tdata", i), {24'd0, tdata3[vt[i].s*8 +: 8]},
                {24'd0, vt[i].d});
            chk($sformatf("v%0d_tready", i), {31'd0, tready3}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_runt", i), {31'd0, runt3}, {31'd0, vt[i].r});
        end
        v3 = 1'b0; tlast = 1'b0;
        #1;
        @(posedge clk);
        #1 chk("runt_one_cycle", {31'd0, runt3}, 32'd0);

        // Reset while inside stream 1's segment.
        seg_len = 16'h0201; ordy3 = 3'b111;
        for (int i = 0; i < 3; i++) begin
            din = 8'hE0 + 8'(i); v3 = 1'b1;
            @(posedge clk);
            #1;
        end
        v3 = 1'b0;
        #1;
        chk("pre_rst_stream", {29'd0, tvalid3 | {2'b00, 1'b0}}, 32'd0);
        do_reset();
        chk("midrst_runt", {31'd0, runt3}, 32'd0);
        din = 8'hE3; v3 = 1'b1;
        #3 chk("midrst_stream0", {29'd0, tvalid3}, 32'd1);
        chk("midrst_tlast", {31'd0, tlast3[0]}, 32'd0);
        @(posedge clk);
        #1 chk("midrst_runt2", {31'd0, runt3}, 32'd0);
        do_reset();

        // Randomized traffic against the segment-level model.
        mon_en = 1'b1;
        for (int p = 0; p < 200; p++) begin
            L  = $urandom_range(1, 12);
            f0 = $urandom_range(0, 4);
            f1 = $urandom_range(0, 4);
            seg_len = {8'(f1), 8'(f0)};
            n0 = (L < f0 + 1) ? L : f0 + 1;
            n1 = ((L - n0) < f1 + 1) ? (L - n0) : f1 + 1;
            if (L <= f0 + f1 + 2) exp_runt++;
            for (int b = 0; b < L; b++) begin
                by  = 8'($urandom);
                s   = (b < n0) ? 0 : ((b < n0 + n1) ? 1 : 2);
                lst = (b == n0 - 1) || (b == n0 + n1 - 1) || (b == L - 1);
                expq[s].push_back({lst, by});
                din = by; tuser = by[0]; tlast = (b == L - 1);
                acc = 1'b0; waitn = 0;
                while (!acc && waitn < 100) begin
                    v3 = ($urandom_range(0, 3) != 0);
                    ordy3 = 3'($urandom_range(0, 7));
                    #3 acc = v3 && tready3;
                    @(posedge clk);
                    #1 waitn++;
                end
                if (!acc) chk("accept_timeout", 32'(waitn), 32'd0);
                // Mid-packet length changes must be ignored.
                if (b == 0) seg_len = 16'($urandom);
            end
        end
        v3 = 1'b0; tlast = 1'b0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b0;
        for (int k = 0; k < 3; k++)
            chk($sformatf("q%0d_drained", k), expq[k].size(), 32'd0);
        chk("runt_count", runt_cnt, exp_runt);

        // Maximum segment length on the two-stream instance.
        do_reset();
        seg_len = 16'h00FF; ordy2 = 2'b11;
        c0 = 0; c1 = 0; l0 = -1; l1 = -1; r2 = 0;
        for (int b = 0; b < 300; b++) begin
            din = 8'(b); tlast = (b == 299); v2 = 1'b1;
            #3;
            if (tvalid2[0]) begin
                c0++;
                if (tlast2[0]) l0 = b;
            end
            if (tvalid2[1]) begin
                c1++;
                if (tlast2[1]) l1 = b;
            end
            @(posedge clk);
            #1 if (runt2) r2++;
        end
        v2 = 1'b0; tlast = 1'b0;
        @(posedge clk);
        #1 if (runt2) r2++;
        chk("max_s0_beats", c0, 32'd256);
        chk("max_s1_beats", c1, 32'd44);
        chk("max_s0_tlast_at", l0, 32'd255);
        chk("max_s1_tlast_at", l1, 32'd299);
        chk("max_runt", r2, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
